// File: rtl/ex_stage_pipe.sv
// Registered LEGv8 execute stage: ALU, shifts, branch resolution and a valid/ready EX/MEM bundle.
// Optional macro EX_MUL_EN builds the iterative shift-add multiplier (alu_ctl 1000); otherwise that code is illegal.
module ex_stage_pipe #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic [ADDR_W-1:0] pc,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] imm,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  input  logic [1:0]        alu_src,
  input  logic [3:0]        alu_ctl,
  input  logic              br,
  input  logic              bz,
  input  logic              bnz,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic              mem_to_reg,
  input  logic              reg_wr,
  input  logic [REG_W-1:0]  rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] store_data,
  output logic              zero,
  output logic [ADDR_W-1:0] br_target,
  output logic              pc_src,
  output logic              mem_rd_o,
  output logic              mem_wr_o,
  output logic              mem_to_reg_o,
  output logic              reg_wr_o,
  output logic [REG_W-1:0]  rd_o,
  output logic              err
);
  localparam int SH_W = $clog2(DATA_W);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_LSL  = 4'b0011;
  localparam logic [3:0] OP_LSR  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_PASS = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_NOR  = 4'b1100;

  typedef struct packed {
    logic [ADDR_W-1:0] tgt;
    logic              br, bz, bnz;
    logic [DATA_W-1:0] store;
    logic              mem_rd, mem_wr, mem_to_reg, reg_wr;
    logic [REG_W-1:0]  rd;
  } side_t;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] store;
    logic              zero;
    logic [ADDR_W-1:0] tgt;
    logic              pc_src;
    logic              mem_rd, mem_wr, mem_to_reg, reg_wr;
    logic [REG_W-1:0]  rd;
    logic              err;
  } out_t;

  // Branch decision is taken on the final result so MUL bundles resolve identically to ALU ones.
  function automatic out_t make_out(input side_t s, input logic [DATA_W-1:0] res, input logic ill);
    out_t o;
    o.result     = ill ? '0 : res;
    o.zero       = (o.result == '0);
    o.store      = s.store;
    o.tgt        = s.tgt;
    if (ill)       o.pc_src = 1'b0;
    else if (s.br) o.pc_src = 1'b1;
    else if (s.bz) o.pc_src = o.zero;
    else           o.pc_src = s.bnz & ~o.zero;
    o.mem_rd     = s.mem_rd;
    o.mem_wr     = s.mem_wr & ~ill;
    o.mem_to_reg = s.mem_to_reg;
    o.reg_wr     = s.reg_wr & ~ill;
    o.rd         = s.rd;
    o.err        = ill;
    return o;
  endfunction

  logic [DATA_W-1:0] op_b, alu_res, mul_res;
  logic              src_ok, ctl_ok, illegal, accept, start_mul, mul_done;
  logic [ADDR_W-1:0] tgt;
  side_t             side_in, mul_side;
  out_t              out_q, out_d;
  logic              out_valid_q, out_valid_d;
`ifdef EX_MUL_EN
  logic              is_mul;
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    op_b   = '0;
    src_ok = 1'b1;
    case (alu_src)
      2'b00:   op_b = data2;
      2'b01:   op_b = imm;
      2'b10:   op_b = DATA_W'(instr[21:10]);
      default: src_ok = 1'b0;
    endcase
  end

  always_comb begin
    alu_res = '0;
    ctl_ok  = 1'b1;
`ifdef EX_MUL_EN
    is_mul  = 1'b0;
`endif
    case (alu_ctl)
      OP_AND:  alu_res = data1 & op_b;
      OP_OR:   alu_res = data1 | op_b;
      OP_ADD:  alu_res = data1 + op_b;
      OP_SUB:  alu_res = data1 - op_b;
      OP_PASS: alu_res = op_b;
      OP_NOR:  alu_res = ~(data1 | op_b);
      OP_LSL:  alu_res = data1 << op_b[SH_W-1:0];
      OP_LSR:  alu_res = data1 >> op_b[SH_W-1:0];
`ifdef EX_MUL_EN
      OP_MUL:  is_mul  = 1'b1;
`endif
      default: ctl_ok  = 1'b0;
    endcase
  end

  assign illegal = ~(src_ok & ctl_ok);

  always_comb begin
    if (br)             tgt = pc + (ADDR_W'($signed(instr[25:0])) << 2);
    else if (bz || bnz) tgt = pc + (ADDR_W'($signed(instr[23:5])) << 2);
    else                tgt = pc;
  end

  always_comb begin
    side_in.tgt        = tgt;
    side_in.br         = br;
    side_in.bz         = bz;
    side_in.bnz        = bnz;
    side_in.store      = data2;
    side_in.mem_rd     = mem_rd;
    side_in.mem_wr     = mem_wr;
    side_in.mem_to_reg = mem_to_reg;
    side_in.reg_wr     = reg_wr;
    side_in.rd         = rd;
  end

  assign accept = in_valid & in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept && !start_mul) begin
      out_valid_d = 1'b1;
      out_d       = make_out(side_in, alu_res, illegal);
    end else if (mul_done) begin
      out_valid_d = 1'b1;
      out_d       = make_out(mul_side, mul_res, 1'b0);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

`ifdef EX_MUL_EN
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;
  localparam int         CNT_W   = SH_W + 1;

  logic [0:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  side_t             side_q, side_d;

  assign start_mul = accept & is_mul & ~illegal;
  assign in_ready  = ~rst & (state_q == ST_IDLE) & ~flush & (~out_valid_q | out_ready);
  assign mul_side  = side_q;
  assign mul_res   = acc_q;

  // With the counter at 0 the product is final; it waits here until the output register is free.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    side_d   = side_q;
    mul_done = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (state_q == ST_IDLE) begin
      if (start_mul) begin
        state_d  = ST_MUL;
        cnt_d    = CNT_W'(DATA_W);
        mcand_d  = data1;
        mplier_d = op_b;
        acc_d    = '0;
        side_d   = side_in;
      end
    end else if (cnt_q != '0) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CNT_W'(1);
    end else if (!out_valid_q || out_ready) begin
      mul_done = 1'b1;
      state_d  = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      side_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      side_q   <= side_d;
    end
  end
`else
  assign start_mul = 1'b0;
  assign mul_done  = 1'b0;
  assign mul_side  = '0;
  assign mul_res   = '0;
  assign in_ready  = ~rst & ~flush & (~out_valid_q | out_ready);
`endif

  assign out_valid    = out_valid_q;
  assign result       = out_q.result;
  assign store_data   = out_q.store;
  assign zero         = out_q.zero;
  assign br_target    = out_q.tgt;
  assign pc_src       = out_q.pc_src;
  assign mem_rd_o     = out_q.mem_rd;
  assign mem_wr_o     = out_q.mem_wr;
  assign mem_to_reg_o = out_q.mem_to_reg;
  assign reg_wr_o     = out_q.reg_wr;
  assign rd_o         = out_q.rd;
  assign err          = out_q.err;
endmodule

// File: tb/tb_ex_stage_pipe.sv
// Scoreboard bench for ex_stage_pipe: directed cases plus randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_ex_stage_pipe;
  localparam int DW = 64;
  localparam int AW = 64;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, flush, out_valid, out_ready;
  logic [AW-1:0] pc, br_target;
  logic [31:0]   instr;
  logic [DW-1:0] imm, data1, data2, result, store_data;
  logic [1:0]    alu_src;
  logic [3:0]    alu_ctl;
  logic          br, bz, bnz, mem_rd, mem_wr, mem_to_reg, reg_wr;
  logic [RW-1:0] rd, rd_o;
  logic          zero, pc_src, mem_rd_o, mem_wr_o, mem_to_reg_o, reg_wr_o, err;

  ex_stage_pipe #(.DATA_W(DW), .ADDR_W(AW), .REG_W(RW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .pc(pc), .instr(instr), .imm(imm), .data1(data1), .data2(data2),
    .alu_src(alu_src), .alu_ctl(alu_ctl), .br(br), .bz(bz), .bnz(bnz),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_to_reg(mem_to_reg), .reg_wr(reg_wr), .rd(rd),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .store_data(store_data),
    .zero(zero), .br_target(br_target), .pc_src(pc_src), .mem_rd_o(mem_rd_o),
    .mem_wr_o(mem_wr_o), .mem_to_reg_o(mem_to_reg_o), .reg_wr_o(reg_wr_o), .rd_o(rd_o), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [31:0]   instr;
    logic [DW-1:0] imm, d1, d2;
    logic [1:0]    src;
    logic [3:0]    ctl;
    logic          br, bz, bnz, mrd, mwr, m2r, rwr;
    logic [RW-1:0] rd;
  } bn_t;

  typedef struct packed {
    logic [DW-1:0] result;
    logic [DW-1:0] store;
    logic          zero;
    logic [AW-1:0] tgt;
    logic          pc_src, mem_rd, mem_wr, mem_to_reg, reg_wr;
    logic [RW-1:0] rd;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic exp_t get_out();
    exp_t o;
    o.result = result;     o.store = store_data;   o.zero = zero;
    o.tgt = br_target;     o.pc_src = pc_src;      o.mem_rd = mem_rd_o;
    o.mem_wr = mem_wr_o;   o.mem_to_reg = mem_to_reg_o;
    o.reg_wr = reg_wr_o;   o.rd = rd_o;            o.err = err;
    return o;
  endfunction

  // Reference: straight arithmetic from the operation table and branch rules.
  function automatic exp_t model(input bn_t b);
    exp_t              e;
    logic [DW-1:0]     bv, r;
    bit                ill;
    logic signed [25:0] o26;
    logic signed [18:0] o19;
    longint            off;
    ill = 0; r = '0; bv = '0;
    case (b.src)
      2'd0:    bv = b.d2;
      2'd1:    bv = b.imm;
      2'd2:    bv = DW'(b.instr[21:10]);
      default: ill = 1;
    endcase
    case (b.ctl)
      4'd0:  r = b.d1 & bv;
      4'd1:  r = b.d1 | bv;
      4'd2:  r = b.d1 + bv;
      4'd6:  r = b.d1 - bv;
      4'd7:  r = bv;
      4'd12: r = ~(b.d1 | bv);
      4'd3:  r = b.d1 << (bv % DW);
      4'd4:  r = b.d1 >> (bv % DW);
`ifdef EX_MUL_EN
      4'd8:  r = b.d1 * bv;
`endif
      default: ill = 1;
    endcase
    if (ill) r = '0;
    e.result = r;
    e.store  = b.d2;
    e.zero   = (r == 0);
    o26 = b.instr[25:0];
    o19 = b.instr[23:5];
    if (b.br)                off = 4 * longint'(o26);
    else if (b.bz || b.bnz)  off = 4 * longint'(o19);
    else                     off = 0;
    e.tgt = b.pc + AW'(off);
    if (ill)        e.pc_src = 0;
    else if (b.br)  e.pc_src = 1;
    else if (b.bz)  e.pc_src = e.zero;
    else            e.pc_src = b.bnz && !e.zero;
    e.mem_rd = b.mrd;  e.mem_wr = b.mwr & !ill;  e.mem_to_reg = b.m2r;
    e.reg_wr = b.rwr & !ill;  e.rd = b.rd;  e.err = ill;
    return e;
  endfunction

  function automatic bn_t mk(input logic [3:0] ctl, input logic [1:0] src,
                             input logic [DW-1:0] d1, input logic [DW-1:0] d2);
    bn_t b = '0;
    b.ctl = ctl; b.src = src; b.d1 = d1; b.d2 = d2;
    return b;
  endfunction

  function automatic bn_t rand_bn();
    bn_t        b;
    logic [3:0] ops [12];
    ops = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd3, 4'd4, 4'd8, 4'd5, 4'd10, 4'd15};
    b.ctl   = ops[$urandom_range(0, 11)];
    b.src   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    b.d1    = {$urandom(), $urandom()};
    b.d2    = ($urandom_range(0, 3) == 0) ? b.d1 : {$urandom(), $urandom()};
    b.imm   = {$urandom(), $urandom()};
    b.pc    = {$urandom(), $urandom()};
    b.instr = $urandom();
    b.br  = ($urandom_range(0, 5) == 0);
    b.bz  = ($urandom_range(0, 3) == 0);
    b.bnz = ($urandom_range(0, 3) == 0);
    b.mrd = 1'($urandom()); b.mwr = 1'($urandom()); b.m2r = 1'($urandom()); b.rwr = 1'($urandom());
    b.rd  = RW'($urandom());
    return b;
  endfunction

  // Called at a falling edge; returns at the next falling edge with in_ready as sampled before the rise.
  task automatic step(input bn_t b, input logic v, input logic ordy, input logic fl, output logic rdy);
    pc = b.pc; instr = b.instr; imm = b.imm; data1 = b.d1; data2 = b.d2;
    alu_src = b.src; alu_ctl = b.ctl; br = b.br; bz = b.bz; bnz = b.bnz;
    mem_rd = b.mrd; mem_wr = b.mwr; mem_to_reg = b.m2r; reg_wr = b.rwr; rd = b.rd;
    in_valid = v; out_ready = ordy; flush = fl;
    #4;
    rdy = in_ready;
    if (in_valid && in_ready) sb.push_back(model(b));
    if (flush) sb.delete();
    @(negedge clk);
  endtask

  task automatic run1(input string nm, input bn_t b, output exp_t got);
    logic r;
    step(b, 1'b1, 1'b1, 1'b0, r);
    check({nm, "_accept"}, r, 1);
    check({nm, "_valid"}, out_valid, 1);
    got = get_out();
  endtask

  // Monitor: pops the scoreboard whenever a bundle is handed to MEM.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) check("sb_unexpected", {out_valid, out_ready}, 0);
        else check("sb_bundle", get_out(), sb.pop_front());
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  bn_t  b, idle;
  bn_t  bp [4];
  exp_t got;
  logic rdy;
  int   k, lat, busy_bad, seen;

  initial begin
    idle = '0;
    rst = 1'b1;
    in_valid = 0; out_ready = 0; flush = 0; pc = '0; instr = '0; imm = '0;
    data1 = '0; data2 = '0; alu_src = '0; alu_ctl = '0; br = 0; bz = 0; bnz = 0;
    mem_rd = 0; mem_wr = 0; mem_to_reg = 0; reg_wr = 0; rd = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset_outputs", {get_out(), out_valid, in_ready}, '0);
    rst = 1'b0;

    // Async reset in the middle of traffic (mid-multiply when the multiplier is built).
    step(idle, 0, 1, 0, rdy);
    step(mk(4'd8, 2'd0, '1, 64'd3), 1, 1, 0, rdy);
    step(idle, 0, 0, 0, rdy);
    step(idle, 0, 0, 0, rdy);
    #2 rst = 1'b1;
    #1;
    check("async_reset", {get_out(), out_valid, in_ready}, '0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    step(idle, 0, 1, 0, rdy);
    check("reset_idle_ready", rdy, 1);

    run1("add", mk(4'd2, 2'd0, 64'd5, 64'd7), got);
    check("add_result", got.result, 12);
    check("add_zero", got.zero, 0);

    b = mk(4'd6, 2'd0, 64'd9, 64'd9); b.bz = 1; b.pc = 64'h100; b.instr = 32'd3 << 5;
    run1("sub_bz", b, got);
    check("sub_bz_result", got.result, 0);
    check("sub_bz_zero", got.zero, 1);
    check("sub_bz_pc_src", got.pc_src, 1);
    check("sub_bz_target", got.tgt, 64'h10C);
    b.bz = 0; b.bnz = 1;
    run1("sub_bnz", b, got);
    check("sub_bnz_pc_src", got.pc_src, 0);

    b = mk(4'd2, 2'd0, 64'd1, 64'd2); b.br = 1; b.pc = 64'h100; b.instr = 32'h03FF_FFFF;
    run1("br", b, got);
    check("br_target", got.tgt, 64'hFC);
    check("br_pc_src", got.pc_src, 1);

    b = mk(4'b1010, 2'd0, 64'd3, 64'd4); b.rwr = 1; b.mwr = 1;
    run1("ill_ctl", b, got);
    check("ill_ctl_err_res_wr", {got.err, got.result, got.reg_wr, got.mem_wr}, {1'b1, 64'd0, 1'b0, 1'b0});
    run1("ill_src", mk(4'd2, 2'd3, 64'd3, 64'd4), got);
    check("ill_src_err", got.err, 1);

    b = mk(4'd3, 2'd2, 64'd1, 64'd0); b.instr = 32'h43 << 10;
    run1("lsl", b, got);
    check("lsl_result", got.result, 8);

    // Back-pressure: MEM stalls for three cycles while ID keeps offering.
    step(idle, 0, 1, 0, rdy);
    for (int i = 0; i < 4; i++) begin
      bp[i] = rand_bn(); bp[i].ctl = 4'd2; bp[i].src = 2'd0;
    end
    k = 0;
    for (int c = 0; c < 4; c++) begin
      step(bp[k], 1, 0, 0, rdy);
      if (rdy) k++;
      if (c > 0) begin
        check("bp_in_ready_low", rdy, 0);
        check("bp_hold", {out_valid, get_out()}, {1'b1, sb[0]});
      end
    end
    for (int c = 0; c < 20 && k < 4; c++) begin
      step(bp[k], 1, 1, 0, rdy);
      if (rdy) k++;
    end
    check("bp_all_accepted", k, 4);

`ifdef EX_MUL_EN
    b = mk(4'd8, 2'd0, '1, 64'd3);
    step(idle, 0, 1, 0, rdy);
    step(b, 1, 1, 0, rdy);
    check("mul_accept", rdy, 1);
    lat = 0; busy_bad = 0;
    while (!out_valid && lat < DW + 10) begin
      step(idle, 0, 1, 0, rdy);
      if (rdy) busy_bad++;
      lat++;
    end
    check("mul_latency", lat, DW + 1);
    check("mul_busy_in_ready", busy_bad, 0);
    check("mul_result", result, 64'hFFFF_FFFF_FFFF_FFFD);
    step(b, 1, 1, 0, rdy);
    check("mulf_accept", rdy, 1);
    for (int c = 1; c < 10; c++) step(idle, 0, 1, 0, rdy);
    step(idle, 0, 1, 1, rdy);
    step(idle, 0, 1, 0, rdy);
    check("flush_ready_next", rdy, 1);
    seen = 0;
    for (int c = 0; c < DW + 5; c++) begin
      step(idle, 0, 1, 0, rdy);
      if (out_valid) seen++;
    end
    check("flush_no_output", seen, 0);
`else
    run1("mul_off", mk(4'd8, 2'd0, '1, 64'd3), got);
    check("mul_off_err_res", {got.err, got.result}, {1'b1, 64'd0});
`endif

    for (int c = 0; c < 600; c++) begin
      step(rand_bn(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 39) == 0), rdy);
    end
    for (int c = 0; c < 3 * DW && sb.size() != 0; c++) step(idle, 0, 1, 0, rdy);
    check("drain_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
